// File: rtl/crg_ctrl_pkg.sv
// Shared types and constants for the CRG enable sequencer.
// Domain indices fix the power-up order (phy first, clk3 last).
package crg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        RUN,
        SW_OFF,
        SW_SEL,
        SW_ON,
        DOWN
    } seq_state_e;

    localparam int N_DOM    = 4;
    localparam int DOM_PHY  = 0;
    localparam int DOM_CLK1 = 1;
    localparam int DOM_CLK2 = 2;
    localparam int DOM_CLK3 = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crg_delay_cnt.sv
// Loadable down-counter that saturates at zero; `zero` reflects the registered count.
// Load takes effect on the next edge; no backpressure.
module crg_delay_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/crg_seq_ctrl.sv
// Clock-enable sequencer for example_crg: ordered power-up/down and glitch-free clk1 source switch.
// Every output is registered (one cycle from the deciding input); requests wait, nothing is dropped.
module crg_seq_ctrl
    import crg_ctrl_pkg::*;
#(
    parameter int   GAP_CYC    = 8,
    parameter int   SETTLE_CYC = 4,
    parameter logic SEL_RST    = 1'b0
) (
    input  logic clk_src,
    input  logic rst_sys,
    input  logic start,
    input  logic stop,
    input  logic sel_req,
    input  logic sel_val,
    output logic sel_ack,
    output logic clk_phy_en,
    output logic clk1_en,
    output logic clk2_en,
    output logic clk3_en,
    output logic clk1_sel,
    output logic seq_busy,
    output logic seq_up
);

    localparam int CNT_W = $clog2(max_int(GAP_CYC, SETTLE_CYC) + 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYC - 1);

    seq_state_e       state_q, state_d;
    logic [N_DOM-1:0] en_q, en_d;
    logic             sel_q, sel_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             up_q, up_d;
    logic             stop_pend_q, stop_pend_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             req_ok;
    logic             stop_any;

    crg_delay_cnt #(.W(CNT_W)) u_delay_cnt (
        .clk   (clk_src),
        .rst   (rst_sys),
        .load  (cnt_load),
        .value (cnt_val),
        .zero  (cnt_zero)
    );

    // While the ack is on the wire the requester has not yet dropped sel_req.
    assign req_ok   = sel_req && !ack_q;
    assign stop_any = stop || stop_pend_q;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        sel_d       = sel_q;
        ack_d       = 1'b0;
        stop_pend_d = stop_pend_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = UP;
                    en_d[DOM_PHY]   = 1'b1;
                    cnt_load        = 1'b1;
                    cnt_val         = GAP_LD;
                end else if (req_ok) begin
                    sel_d = sel_val;
                    ack_d = 1'b1;
                end
            end
            UP: begin
                stop_pend_d = stop_any;
                if (cnt_zero) begin
                    en_d = {en_q[N_DOM-2:0], 1'b1};
                    if (en_q[DOM_CLK2]) begin
                        if (stop_any) begin
                            // Zero load: the first clear happens right after entering DOWN.
                            state_d     = DOWN;
                            stop_pend_d = 1'b0;
                            cnt_load    = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LD;
                    end
                end
            end
            RUN: begin
                if (stop_any) begin
                    state_d        = DOWN;
                    stop_pend_d    = 1'b0;
                    en_d[DOM_CLK3] = 1'b0;
                    cnt_load       = 1'b1;
                    cnt_val        = GAP_LD;
                end else if (req_ok) begin
                    if (sel_val == sel_q) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d        = SW_OFF;
                        en_d[DOM_CLK1] = 1'b0;
                        cnt_load       = 1'b1;
                        cnt_val        = SET_LD;
                    end
                end
            end
            SW_OFF: begin
                stop_pend_d = stop_any;
                if (cnt_zero) begin
                    state_d  = SW_SEL;
                    sel_d    = sel_val;
                    cnt_load = 1'b1;
                    cnt_val  = SET_LD;
                end
            end
            SW_SEL: begin
                stop_pend_d = stop_any;
                if (cnt_zero) begin
                    state_d        = SW_ON;
                    en_d[DOM_CLK1] = 1'b1;
                    ack_d          = 1'b1;
                end
            end
            SW_ON: begin
                if (stop_any) begin
                    state_d     = DOWN;
                    stop_pend_d = 1'b0;
                    cnt_load    = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DOWN: begin
                stop_pend_d = 1'b0;
                if (en_q == '0) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    en_d     = en_q >> 1;
                    cnt_load = 1'b1;
                    cnt_val  = GAP_LD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = !(state_d == IDLE || state_d == RUN);
        up_d   = (state_d inside {RUN, SW_OFF, SW_SEL, SW_ON});
    end

    always_ff @(posedge clk_src) begin
        if (rst_sys) begin
            state_q     <= IDLE;
            en_q        <= '0;
            sel_q       <= SEL_RST;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            up_q        <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            up_q        <= up_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign clk_phy_en = en_q[DOM_PHY];
    assign clk1_en    = en_q[DOM_CLK1];
    assign clk2_en    = en_q[DOM_CLK2];
    assign clk3_en    = en_q[DOM_CLK3];
    assign clk1_sel   = sel_q;
    assign sel_ack    = ack_q;
    assign seq_busy   = busy_q;
    assign seq_up     = up_q;

endmodule

// File: tb/tb_crg_seq_ctrl.sv
// Bench for crg_seq_ctrl: expected waveforms come from the documented edge-time formulas.
module tb_crg_seq_ctrl;

    localparam int   G       = 8;
    localparam int   S       = 4;
    localparam logic SEL_RST = 1'b0;

    logic clk_src = 1'b0;
    logic rst_sys, start, stop, sel_req, sel_val;
    logic sel_ack, clk_phy_en, clk1_en, clk2_en, clk3_en, clk1_sel, seq_busy, seq_up;
    logic [7:0] obs;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic m_sel;
    bit   pend;

    crg_seq_ctrl #(.GAP_CYC(G), .SETTLE_CYC(S), .SEL_RST(SEL_RST)) dut (
        .clk_src    (clk_src),
        .rst_sys    (rst_sys),
        .start      (start),
        .stop       (stop),
        .sel_req    (sel_req),
        .sel_val    (sel_val),
        .sel_ack    (sel_ack),
        .clk_phy_en (clk_phy_en),
        .clk1_en    (clk1_en),
        .clk2_en    (clk2_en),
        .clk3_en    (clk3_en),
        .clk1_sel   (clk1_sel),
        .seq_busy   (seq_busy),
        .seq_up     (seq_up)
    );

    always #5 clk_src = ~clk_src;

    assign obs = {clk3_en, clk2_en, clk1_en, clk_phy_en, clk1_sel, sel_ack, seq_busy, seq_up};

    function automatic logic [7:0] ev(input logic [3:0] en, input logic sel, input logic ack,
                                      input logic busy, input logic up);
        return {en, sel, ack, busy, up};
    endfunction

    // k cycles after start: domain i is on once k >= 1 + i*G.
    function automatic logic [3:0] up_en(input int k);
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (k >= 1 + i * G);
        return e;
    endfunction

    // k cycles after stop: domain i is still on while k < 1 + (3-i)*G.
    function automatic logic [3:0] down_en(input int k);
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (k < 1 + (3 - i) * G);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_src);
        #1;
        cyc++;
    endtask

    task automatic do_idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("idle", ev(4'h0, m_sel, 1'b0, 1'b0, 1'b0));
            stop = 1'($urandom_range(0, 1));
        end
        stop = 1'b0;
    endtask

    task automatic do_run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("run_hold", ev(4'hF, m_sel, 1'b0, 1'b0, 1'b1));
            start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
    endtask

    task automatic do_up(input int stop_off, input bit req_up, output bit p);
        p     = (stop_off > 0);
        start = 1'b1;
        for (int k = 1; k <= 3 * G + 1; k++) begin
            tick();
            chk("up", ev(up_en(k), m_sel, 1'b0, (k < 1 + 3 * G) || p, (k >= 1 + 3 * G) && !p));
            start = 1'($urandom_range(0, 3) == 0);
            stop  = (k == stop_off);
            if (req_up && k == 1) begin
                sel_req = 1'b1;
                sel_val = ~m_sel;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_down(input bit from_run, input bit req_pend);
        if (from_run) stop = 1'b1;
        for (int k = 1; k <= 2 + 3 * G; k++) begin
            tick();
            chk("down", ev(down_en(k), m_sel, 1'b0, k < 2 + 3 * G, 1'b0));
            stop  = 1'($urandom_range(0, 1));
            start = (k <= 3 * G) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        stop  = 1'b0;
        start = 1'b0;
        if (req_pend) begin
            tick();
            m_sel = sel_val;
            chk("idle_ack", ev(4'h0, m_sel, 1'b1, 1'b0, 1'b0));
            tick();
            sel_req = 1'b0;
            chk("idle_blank", ev(4'h0, m_sel, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic do_switch(input logic val, input int stop_off, output bit p);
        logic old;
        old     = m_sel;
        sel_req = 1'b1;
        sel_val = val;
        p       = 1'b0;
        if (val == old) begin
            tick();
            chk("same_ack", ev(4'hF, old, 1'b1, 1'b0, 1'b1));
            tick();
            sel_req = 1'b0;
            chk("same_blank", ev(4'hF, old, 1'b0, 1'b0, 1'b1));
        end else begin
            for (int k = 1; k <= 1 + 2 * S; k++) begin
                tick();
                chk("switch", ev((k <= 2 * S) ? 4'b1101 : 4'hF, (k >= 1 + S) ? val : old,
                                 k == 1 + 2 * S, 1'b1, 1'b1));
                stop = (k == stop_off);
            end
            m_sel = val;
            p     = (stop_off > 0);
            tick();
            stop    = 1'b0;
            sel_req = 1'b0;
            chk("switch_end", ev(4'hF, val, 1'b0, p, !p));
        end
    endtask

    task automatic do_rst_mid();
        logic old;
        old     = m_sel;
        sel_req = 1'b1;
        sel_val = ~old;
        for (int k = 1; k <= S + 2; k++) begin
            tick();
            chk("pre_rst", ev(4'b1101, (k >= 1 + S) ? ~old : old, 1'b0, 1'b1, 1'b1));
        end
        rst_sys = 1'b1;
        sel_req = 1'b0;
        tick();
        rst_sys = 1'b0;
        m_sel   = SEL_RST;
        chk("rst_mid", ev(4'h0, SEL_RST, 1'b0, 1'b0, 1'b0));
        do_idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_sys = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        sel_req = 1'b0;
        sel_val = 1'b0;
        m_sel   = SEL_RST;

        tick();
        chk("reset", ev(4'h0, SEL_RST, 1'b0, 1'b0, 1'b0));
        tick();
        rst_sys = 1'b0;
        chk("reset_hold", ev(4'h0, SEL_RST, 1'b0, 1'b0, 1'b0));
        do_idle(8);

        // Start at 10, stop at 50.
        do_up(0, 1'b0, pend);
        do_run(15);
        do_down(1'b1, 1'b0);

        // Switch to 1, same-value request, then switch back with a stop mid-switch.
        do_idle(4);
        do_up(0, 1'b0, pend);
        do_run(3);
        do_switch(1'b1, 0, pend);
        do_run(2);
        do_switch(1'b1, 0, pend);
        do_switch(1'b0, 3, pend);
        do_down(1'b0, 1'b0);

        // Select request served in IDLE while idle.
        sel_req = 1'b1;
        sel_val = ~m_sel;
        tick();
        m_sel = sel_val;
        chk("idle_sel_ack", ev(4'h0, m_sel, 1'b1, 1'b0, 1'b0));
        tick();
        sel_req = 1'b0;
        chk("idle_sel_blank", ev(4'h0, m_sel, 1'b0, 1'b0, 1'b0));

        // stop and sel_req together in RUN.
        do_idle(3);
        do_up(0, 1'b0, pend);
        sel_req = 1'b1;
        sel_val = ~m_sel;
        do_down(1'b1, 1'b1);

        // stop during UP.
        do_idle(2);
        do_up(5, 1'b0, pend);
        do_down(1'b0, 1'b0);

        // Reset while in SW_SEL.
        do_up(0, 1'b0, pend);
        do_run(2);
        do_rst_mid();

        // Request raised during UP, serviced on reaching RUN.
        do_up(0, 1'b1, pend);
        do_switch(sel_val, 0, pend);
        do_down(1'b1, 1'b0);

        for (int it = 0; it < 12; it++) begin
            int mode;
            int nsw;
            do_idle($urandom_range(1, 4));
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                do_up($urandom_range(1, 3 * G), 1'b0, pend);
                do_down(1'b0, 1'b0);
            end else begin
                do_up(0, mode == 1, pend);
                if (mode == 1) do_switch(sel_val, 0, pend);
                nsw = $urandom_range(0, 2);
                for (int j = 0; j < nsw && !pend; j++) begin
                    do_switch(1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * S + 1) : 0, pend);
                    if (!pend) do_run($urandom_range(0, 3));
                end
                if (pend) begin
                    do_down(1'b0, 1'b0);
                end else if ($urandom_range(0, 1) == 1) begin
                    sel_req = 1'b1;
                    sel_val = ~m_sel;
                    do_down(1'b1, 1'b1);
                end else begin
                    do_down(1'b1, 1'b0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crg_seq_ctrl.md
# crg_seq_ctrl

Sequencer for the clock/reset generator `example_crg`. It drives the four clock-enable lines `clk_phy_en`, `clk1_en`, `clk2_en` and `clk3_en`, plus the `clk1_sel` mux select.

- Power-up: enables turn on in fixed order with a programmable gap between them.
- Power-down: enables turn off in reverse order.
- Glitch-free `clk1` source switch: gate `clk1`, settle, flip the select, settle, re-enable.

The block sits beside the CRG instance in the top level and runs on the CRG source clock.

## Interface

Parameters:
- `GAP_CYC`, default 8: cycles between successive enable edges in up/down sequences (≥1).
- `SETTLE_CYC`, default 4: cycles between gate, select flip and ungate during a switch (≥1).
- `SEL_RST`, default 1'b0: reset value of `clk1_sel`.

Ports:
- `clk_src`, in, 1: the only clock.
- `rst_sys`, in, 1: reset. One clock; reset is synchronous and active-high.
- `start`, in, 1: pulse that starts power-up. Honoured only in IDLE.
- `stop`, in, 1: pulse that requests power-down.
- `sel_req`, in, 1: level. Held together with `sel_val` until `sel_ack`.
- `sel_val`, in, 1: requested `clk1_sel` value.
- `sel_ack`, out, 1: one-cycle pulse marking request completion.
- `clk_phy_en`, `clk1_en`, `clk2_en`, `clk3_en`, out, 1 each: CRG clock enables.
- `clk1_sel`, out, 1: CRG `clk1` source select.
- `seq_busy`, out, 1: high in every state except IDLE and RUN.
- `seq_up`, out, 1: high in RUN and during switch states.

## Operation

Enables are held in a 4-bit register, index 0=phy, 1=clk1, 2=clk2, 3=clk3. All outputs are registered.

States:
- **IDLE** (all enables 0)
  - `start` → UP.
  - `sel_req` → `clk1_sel`←`sel_val` and `sel_ack` both on the next cycle; stay in IDLE.
- **UP**: sets `en[0..3]` one at a time, every `GAP_CYC` cycles. After `en[3]` is set → RUN, or → DOWN if `stop_pend`.
- **RUN**
  - `stop` (or `stop_pend`) → DOWN.
  - Else `sel_req`:
    - `sel_val==clk1_sel` → ack next cycle, stay in RUN.
    - Otherwise → SW_OFF.
- **SW_OFF**: `clk1_en`←0 on entry. After `SETTLE_CYC` → SW_SEL.
- **SW_SEL**: `clk1_sel`←`sel_val`. After `SETTLE_CYC` → SW_ON.
- **SW_ON**: `clk1_en`←1 and `sel_ack` pulse in the same cycle. → RUN, or → DOWN if `stop_pend`.
- **DOWN**: clears `en[3..0]` one at a time, every `GAP_CYC` cycles. After `en[0]` is cleared → IDLE.

Boundary rules:
- `stop` during UP or any SW state sets `stop_pend`; the stop is honoured when that state completes. `stop_pend` is cleared on entering DOWN.
- `start` outside IDLE is ignored and not latched.
- `stop` in IDLE or DOWN is ignored.
- `stop` and `sel_req` asserted together in RUN: stop wins. `sel_req` stays pending and is serviced in IDLE after the down sequence.
- `sel_req` in UP or DOWN is not serviced; it is serviced on reaching RUN or IDLE.
- Ack blanking: in the cycle after `sel_ack`, `sel_req` is ignored. The requester must drop `sel_req` in that cycle.
- Reset mid-operation, on the first clock edge with `rst_sys`=1:
  - all enables 0, `clk1_sel`=`SEL_RST`;
  - `sel_ack`, `seq_busy`, `seq_up` = 0;
  - `stop_pend`=0, state IDLE, counter 0.

## Timing

- Reset values: all outputs 0, except `clk1_sel`=`SEL_RST`.
- `start` at cycle t:
  - `clk_phy_en`↑ at t+1, `clk1_en`↑ at t+1+G, `clk2_en`↑ at t+1+2G, `clk3_en`↑ at t+1+3G, where G=`GAP_CYC`.
  - `seq_up`↑ and `seq_busy`↓ both at t+1+3G.
- `stop` in RUN at cycle t:
  - `clk3_en`↓ at t+1, `clk2_en`↓ at t+1+G, `clk1_en`↓ at t+1+2G, `clk_phy_en`↓ at t+1+3G.
  - State is IDLE and `seq_busy`↓ at t+2+3G.
- Switch with `sel_req` at cycle t in RUN, S=`SETTLE_CYC`:
  - `clk1_en`↓ at t+1.
  - `clk1_sel` flips at t+1+S.
  - `clk1_en`↑ and `sel_ack` at t+1+2S.
- Counter width is `$clog2(max(GAP_CYC,SETTLE_CYC)+1)`. The counter loads on each state/step entry, counts down to 0, and never wraps.

## Structure

- Package `crg_ctrl_pkg`:
  - state enum (`IDLE`, `UP`, `RUN`, `SW_OFF`, `SW_SEL`, `SW_ON`, `DOWN`);
  - domain index constants `DOM_PHY`=0 … `DOM_CLK3`=3;
  - `N_DOM`=4.
- Sub-module `crg_delay_cnt`: loadable down-counter with `load`/`value`/`zero` ports. It is shared by the gap and settle waits.

## Test plan

- **Reset then start** (G=8): `start` at cycle 10 → enables rise at cycles 11/19/27/35; `seq_up`=1 at 35.
- **Stop from RUN** (G=8): `stop` at cycle 50 → enables fall at 51 (clk3), 59 (clk2), 67 (clk1), 75 (phy); `seq_busy`=0 at 76.
- **Switch** (S=4): in RUN, `sel_req`=1 with `sel_val`=1 and `clk1_sel`=0 at cycle 100 → `clk1_en`=0 at 101, `clk1_sel`=1 at 105, `clk1_en`=1 and `sel_ack` at 109. `clk2_en` stays 1 throughout.
- **Same-value switch**: `sel_val`==`clk1_sel` → `sel_ack` the next cycle, no enable change.
- **Collisions**:
  - `stop` during UP → full up sequence completes, then down starts the next cycle.
  - `stop` and `sel_req` in the same cycle → down sequence, then the select is applied in IDLE with ack.
- **Reset mid-switch**: `rst_sys` asserted in SW_SEL → next cycle all enables 0, `clk1_sel`=`SEL_RST`, no `sel_ack`.
